// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and round-robin pick function for mux4_rr_arbiter
package arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 2;

    // First set request bit scanning ptr, ptr+1, ... (mod NUM_REQ).
    // Walking downward lets the lowest offset win by being written last.
    // With no request set the result is ptr and the caller must not use it.
    function automatic logic [REQ_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [REQ_W-1:0]   ptr);
        logic [REQ_W-1:0] pick;
        logic [REQ_W-1:0] idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + REQ_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - producer/consumer bundle of the four-way packet arbiter
interface mux4_rr_arbiter_if #(parameter int N = 16);

    logic [arb_pkg::NUM_REQ-1:0] in_valid;
    logic [arb_pkg::NUM_REQ-1:0] in_last;
    logic [N-1:0]                in_data0;
    logic [N-1:0]                in_data1;
    logic [N-1:0]                in_data2;
    logic [N-1:0]                in_data3;
    logic [arb_pkg::NUM_REQ-1:0] in_ready;
    logic                        out_valid;
    logic [N-1:0]                out_data;
    logic                        out_last;
    logic                        out_ready;
    logic [arb_pkg::REQ_W-1:0]   grant;
    logic                        busy;

    // Environment side: drives the producers and the consumer ready
    modport master (
        output in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant, busy
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_last, grant, busy
    );

endinterface

// File: rtl/mux4.sv
// rtl/mux4.sv - four-input N-bit multiplexer
module mux4 #(
    parameter int N = 16
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Plain select; every case covered so no latch can form
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin packet arbiter sharing one channel among four requesters
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mux4_rr_arbiter_if.slave    bus
);

    arb_state_t          state_q;
    logic [REQ_W-1:0]    grant_q;
    logic [REQ_W-1:0]    ptr_q;
    logic                busy_q;

    logic [REQ_W-1:0]    grant_d;
    logic [REQ_W-1:0]    ptr_d;
    logic                locked;
    logic                out_valid_c;
    logic                out_last_c;
    logic [NUM_REQ-1:0]  in_ready_c;
    logic                xfer;
    logic                pkt_done;

    assign locked = (state_q == LOCKED);

    // Owner's handshake is passed straight through while locked; everyone else sees ready low
    always_comb begin
        out_valid_c = locked & bus.in_valid[grant_q];
        out_last_c  = out_valid_c & bus.in_last[grant_q];
        in_ready_c  = '0;
        if (locked) begin
            in_ready_c[grant_q] = bus.out_ready;
        end
    end

    assign xfer     = out_valid_c & bus.out_ready;
    assign pkt_done = xfer & out_last_c;
    assign grant_d  = rr_pick(bus.in_valid, ptr_q);
    assign ptr_d    = grant_q + REQ_W'(1);

    // Ownership FSM: grab on any request in IDLE, release after the last beat transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.in_valid) begin
                        grant_q <= grant_d;
                        state_q <= LOCKED;
                        busy_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mux4 #(.N(N)) u_mux4 (
        .d0  (bus.in_data0),
        .d1  (bus.in_data1),
        .d2  (bus.in_data2),
        .d3  (bus.in_data3),
        .sel (grant_q),
        .y   (bus.out_data)
    );

    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.N(16)) bus ();

    mux4_rr_arbiter #(.N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] td [4];

    int m_owner;
    int m_ptr;
    int m_grant;
    int dut_xfers;

    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        r;
        logic        ov;
        logic [3:0]  ir;
        logic        ol;
        logic [1:0]  g;
        logic        b;
        logic [15:0] d;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = r;
        bus.in_data0  = td[0];
        bus.in_data1  = td[1];
        bus.in_data2  = td[2];
        bus.in_data3  = td[3];
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_grant = 0;
    endtask

    // Reference: an owner index (or none), a priority pointer and the last grant.
    task automatic model_edge(input logic [3:0] v, input logic [3:0] l, input logic r);
        int idx;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (m_owner < 0 && v[idx]) begin
                    m_owner = idx;
                    m_grant = idx;
                end
            end
        end else if (v[m_owner] && r && l[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end
    endtask

    // One clock: apply inputs, compare against the reference, clock, advance the reference
    task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic r, input string tag);
        logic       e_ov;
        logic       e_ol;
        logic [3:0] e_ir;
        logic [15:0] e_d;
        drive(v, l, r);
        #3;
        e_ov = 1'b0;
        e_ol = 1'b0;
        e_ir = 4'h0;
        e_d  = 16'h0;
        if (m_owner >= 0) begin
            e_ov = v[m_owner];
            e_ol = v[m_owner] & l[m_owner];
            e_ir = r ? (4'h1 << m_owner) : 4'h0;
            e_d  = td[m_owner];
        end
        chk({tag, " out_valid"}, bus.out_valid, e_ov);
        chk({tag, " out_last"},  bus.out_last,  e_ol);
        chk({tag, " in_ready"},  bus.in_ready,  e_ir);
        chk({tag, " grant"},     bus.grant,     m_grant);
        chk({tag, " busy"},      bus.busy,      (m_owner >= 0));
        if (e_ov) chk({tag, " out_data"}, bus.out_data, e_d);
        if (bus.out_valid && r) dut_xfers++;
        @(posedge clk);
        #1;
        if (rst_n) model_edge(v, l, r);
        else model_reset();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int j = 0; j < 4; j++) td[j] = 16'hA000 + 16'(j);
        model_reset();
        drive(4'hF, 4'h0, 1'b1);
        @(posedge clk);
        #1;

        // Reset held with every requester asking
        cycle(4'hF, 4'h0, 1'b1, "rst_hold");
        chk("rst_hold_ready", bus.in_ready, 4'h0);
        rst_n = 1'b1;
        cycle(4'hF, 4'h0, 1'b1, "rst_rel");
        chk("rst_rel_grant", bus.grant, 2'd0);
        chk("rst_rel_busy", bus.busy, 1'b1);

        // Fair rotation with 2-beat packets, hand-derived expectations
        tbl[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1, 16'hA000};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 16'hA000};
        tbl[3]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[4]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 2'd1, 1'b1, 16'hA001};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 16'hA001};
        tbl[6]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b0, 16'h0000};
        tbl[7]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h4, 1'b0, 2'd2, 1'b1, 16'hA002};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 16'hA002};
        tbl[9]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 16'h0000};
        tbl[10] = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h8, 1'b0, 2'd3, 1'b1, 16'hA003};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 16'hA003};
        tbl[12] = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 1'b0, 16'h0000};
        tbl[13] = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1, 16'hA000};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].r);
            #3;
            chk($sformatf("tbl%0d out_valid", i), bus.out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d in_ready", i),  bus.in_ready,  tbl[i].ir);
            chk($sformatf("tbl%0d out_last", i),  bus.out_last,  tbl[i].ol);
            chk($sformatf("tbl%0d grant", i),     bus.grant,     tbl[i].g);
            chk($sformatf("tbl%0d busy", i),      bus.busy,      tbl[i].b);
            if (tbl[i].ov) chk($sformatf("tbl%0d out_data", i), bus.out_data, tbl[i].d);
            @(posedge clk);
            #1;
        end

        // Backpressure and owner stall on requester 2; others request while it has dropped valid
        do_reset();
        cycle(4'b0100, 4'h0, 1'b1, "bp_arb");
        dut_xfers = 0;
        td[2] = 16'h2001;
        cycle(4'b0100, 4'h0, 1'b0, "bp_stall0");
        cycle(4'b0100, 4'h0, 1'b1, "bp_beat1");
        td[2] = 16'h2002;
        cycle(4'b1011, 4'h0, 1'b1, "bp_drop0");
        cycle(4'b1011, 4'h0, 1'b1, "bp_drop1");
        cycle(4'b0100, 4'h0, 1'b0, "bp_stall1");
        cycle(4'b0100, 4'h0, 1'b1, "bp_beat2");
        td[2] = 16'h2003;
        cycle(4'b0100, 4'b0100, 1'b0, "bp_stall2");
        chk("bp_grant_held", bus.grant, 2'd2);
        cycle(4'b0100, 4'b0100, 1'b1, "bp_beat3");
        chk("bp_xfers", dut_xfers, 3);
        chk("bp_released", bus.busy, 1'b0);

        // Lock on requester 3 while 0 asks; pointer wraps to 0
        for (int j = 0; j < 4; j++) td[j] = 16'hB000 + 16'(j);
        do_reset();
        cycle(4'b1000, 4'h0, 1'b1, "wr_arb");
        cycle(4'b1000, 4'h0, 1'b1, "wr_beat1");
        cycle(4'b1001, 4'h0, 1'b1, "wr_beat2");
        chk("wr_lock_grant", bus.grant, 2'd3);
        cycle(4'b1001, 4'b1000, 1'b1, "wr_last");
        chk("wr_idle_grant", bus.grant, 2'd3);
        cycle(4'b0001, 4'h0, 1'b1, "wr_turn");
        chk("wr_new_grant", bus.grant, 2'd0);
        chk("wr_new_busy", bus.busy, 1'b1);
        cycle(4'b0001, 4'b0001, 1'b1, "wr_pkt0");

        // Single-beat packets from 1 then 2
        do_reset();
        cycle(4'b0110, 4'b0110, 1'b1, "sb_arb1");
        chk("sb_grant1", bus.grant, 2'd1);
        cycle(4'b0110, 4'b0110, 1'b1, "sb_beat1");
        chk("sb_busy_drop1", bus.busy, 1'b0);
        cycle(4'b0100, 4'b0100, 1'b1, "sb_arb2");
        chk("sb_grant2", bus.grant, 2'd2);
        cycle(4'b0100, 4'b0100, 1'b1, "sb_beat2");
        chk("sb_busy_drop2", bus.busy, 1'b0);

        // Reset pulsed during beat 2 of a packet from requester 1
        do_reset();
        cycle(4'b0010, 4'h0, 1'b1, "rm_arb");
        cycle(4'b0010, 4'h0, 1'b1, "rm_beat1");
        drive(4'b0010, 4'h0, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rm_out_valid", bus.out_valid, 1'b0);
        chk("rm_in_ready", bus.in_ready, 4'h0);
        chk("rm_busy", bus.busy, 1'b0);
        chk("rm_grant", bus.grant, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'hF, 4'h0, 1'b1, "rm_restart");
        chk("rm_restart_grant", bus.grant, 2'd0);

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < 4; j++) td[j] = 16'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin packet arbiter that shares one N-bit output channel among four valid/ready requesters. It uses a `mux4` instance as its datapath and drives the mux select from a registered grant. Grant is held for a whole packet, up to and including the beat flagged `last`. It sits between the four producer ports and any single-consumer resource.

## Interface
- `N`, default 16: data width of every input and output data port.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 4: per-requester valid; bit i belongs to requester i.
- `in_last` in 4: per-requester end-of-packet flag; qualified by the matching `in_valid`.
- `in_data0`..`in_data3` in N each: requester payloads; these are the `mux4` inputs d0..d3.
- `in_ready` out 4: per-requester ready; one-hot or zero.
- `out_valid` out 1: shared channel valid.
- `out_data` out N: shared channel payload, equal to the `mux4` output.
- `out_last` out 1: shared channel end-of-packet flag.
- `out_ready` in 1: consumer ready.
- `grant` out 2: registered index of the current or last owner; also the `mux4` select.
- `busy` out 1: high while a packet is owned (LOCKED state).

## Operation
- States:
  - IDLE: no owner.
  - LOCKED: requester `grant` owns the channel.
- Priority pointer `ptr` (2 bits) names the highest-priority requester.
- **IDLE**
  - Outputs: `out_valid`=0, `out_last`=0, `in_ready`=0.
  - If any `in_valid` bit is set, select the first set bit scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - On that edge, load `grant` with the selected index and enter LOCKED.
  - If no `in_valid` bit is set, stay in IDLE; `grant` and `ptr` are unchanged.
- **LOCKED**
  - `out_valid` = `in_valid[grant]`.
  - `out_last` = `in_last[grant]` & `in_valid[grant]`.
  - `out_data` = `in_data` of the granted requester, through the `mux4`.
  - `in_ready[grant]` = `out_ready`; every other `in_ready` bit is 0.
  - A beat transfers when `out_valid` & `out_ready`.
  - A transfer with `out_last`=1 ends the packet: on that edge return to IDLE and set `ptr` = `grant`+1 (mod 4, so 3 wraps to 0).
  - A transfer without `last` stays in LOCKED.
- Owner deasserts `in_valid` mid-packet: grant is held, `out_valid`=0, other requesters stay blocked.
- Requests from non-owners during LOCKED are ignored until the return to IDLE.
- A single-beat packet (`last` set on the first beat) is legal.
- Fairness: with all four requesting continuously, grants cycle 0,1,2,3,0,… from reset. A waiting requester is granted within at most 3 other packets.
- `out_data` in IDLE equals `in_data[grant]` and is don't-care; checkers sample it only when `out_valid`=1.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state IDLE, `grant`=0, `ptr`=0, `busy`=0.
  - Therefore `out_valid`=0, `out_last`=0, `in_ready`=0.
- Reset asserted mid-packet aborts the packet. Nothing is held over; the beat in flight is not transferred.
- Arbitration latency:
  - Request seen in IDLE at edge k gives `busy`=1 and `grant` valid after edge k.
  - The first beat can transfer in cycle k+1.
- `out_valid`, `out_data`, `out_last` and `in_ready` are combinational from the inputs plus registered state, with no added data latency. `out_ready` → `in_ready` is a combinational path.
- Packet turnaround: exactly one IDLE cycle between the `last` transfer and the next grant. Peak throughput is therefore L/(L+1) for L-beat packets.
- `grant` changes only on the IDLE→LOCKED edge.

## Structure
- Shared package `arb_pkg`:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`
  - `localparam int NUM_REQ = 4`
  - `localparam int REQ_W = 2`
- Sub-module: the existing `mux4 #(.N(N))`, instanced once; its select is `grant`.
- Round-robin priority selection is a combinational function in `arb_pkg` (`rr_pick(req, ptr)`); it is not a separate module.

## Test plan
- **Reset:** hold `rst_n`=0 with all `in_valid`=4'hF → `out_valid`=0, `in_ready`=0, `grant`=0, `busy`=0. Release reset → `grant`=0 one edge later.
- **Fair rotation:** all four requesters send 2-beat packets with data 16'hA000+i, `out_ready`=1 → grant order 0,1,2,3,0. Each packet is 2 transfers followed by 1 idle cycle.
- **Backpressure and owner stall:** requester 2 alone sends a 3-beat packet; `out_ready` is toggled and `in_valid[2]` dropped for 2 cycles mid-packet → no beat lost or duplicated, `grant` stays 2, `in_ready[2]` tracks `out_ready`.
- **Lock and pointer wrap:** requester 3 is granted; requester 0 raises `in_valid` mid-packet → requester 0 is not granted until after 3's `last`. `ptr` wraps to 0, and 0 is granted one cycle after 3's `last` transfer.
- **Single-beat packets:** requesters 1 and 2 each send one beat with `last`=1 → `out_last`=1 on each, grants are 1 then 2, and `busy` pulses for one cycle each.
- **Reset mid-packet:** `rst_n` pulsed low during beat 2 of a 4-beat packet from requester 1 → outputs go idle immediately. After release, arbitration restarts from `ptr`=0.
